// File: rtl/mod_n_counter_sync_if.sv
// Control and status bundle for mod_n_counter_sync; the parameter must match the counter's MODULUS.
// master drives the count controls, slave is the counter itself.
interface mod_n_counter_sync_if #(
    parameter int MODULUS = 3
);
    localparam int W = $clog2(MODULUS);

    logic         en_i;
    logic         up_i;
    logic         load_i;
    logic [W-1:0] load_val_i;
    logic [W-1:0] count_o;
    logic         tc_o;
    logic         wrap_o;
    logic         load_err_o;

    modport master (
        output en_i, up_i, load_i, load_val_i,
        input  count_o, tc_o, wrap_o, load_err_o
    );

    modport slave (
        input  en_i, up_i, load_i, load_val_i,
        output count_o, tc_o, wrap_o, load_err_o
    );
endinterface

// File: rtl/mod_n_counter_sync.sv
// Parametrised synchronous modulo-N up/down counter with range-checked load,
// registered wrap pulse and a combinational terminal count for cascading.
module mod_n_counter_sync #(
    parameter int MODULUS     = 3,
    parameter int RESET_VALUE = 0
) (
    input  logic                       clk_i,
    input  logic                       clear_i,
    mod_n_counter_sync_if.slave        bus
);
    localparam int W = $clog2(MODULUS);
    localparam logic [W-1:0] MAX_COUNT = W'(MODULUS - 1);
    localparam logic [W-1:0] RST_COUNT = W'(RESET_VALUE);
    localparam logic [W:0]   MOD_EXT   = (W+1)'(MODULUS);

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         loadErr_q, loadErr_d;
    logic         loadOk;
    logic         atTerminal;

    // One extra bit so the range check also works when MODULUS is a power of two.
    assign loadOk     = ({1'b0, bus.load_val_i} < MOD_EXT);
    assign atTerminal = bus.up_i ? (count_q == MAX_COUNT) : (count_q == '0);

    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        loadErr_d = loadErr_q;
        if (bus.load_i) begin
            if (loadOk) begin
                count_d = bus.load_val_i;
            end else begin
                loadErr_d = 1'b1;
            end
        end else if (bus.en_i) begin
            if (atTerminal) begin
                count_d = bus.up_i ? '0 : MAX_COUNT;
                wrap_d  = 1'b1;
            end else if (bus.up_i) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q   <= RST_COUNT;
            wrap_q    <= 1'b0;
            loadErr_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            loadErr_q <= loadErr_d;
        end
    end

    assign bus.count_o    = count_q;
    assign bus.wrap_o     = wrap_q;
    assign bus.load_err_o = loadErr_q;
    // Unregistered so a downstream stage steps on the same edge as this one wraps.
    assign bus.tc_o       = bus.en_i & ~bus.load_i & ~clear_i & atTerminal;
endmodule
